// File: rtl/intr_ctrl_if.sv
// Event, completion, mask and request/status signals between intr_ctrl and its peripherals/fetch.
// slave = the controller; master = the side driving events, rti/rsi and mask writes.
interface intr_ctrl_if;
  logic       key_evt;
  logic       eth_evt;
  logic       rti;
  logic       rsi;
  logic       mask_we;
  logic [1:0] mask_wdata;
  logic       interrupt_key;
  logic       interrupt_eth;
  logic [1:0] irq_cause;
  logic [1:0] irq_ovf;
  logic       busy;

  modport master (
    output key_evt, eth_evt, rti, rsi, mask_we, mask_wdata,
    input  interrupt_key, interrupt_eth, irq_cause, irq_ovf, busy
  );

  modport slave (
    input  key_evt, eth_evt, rti, rsi, mask_we, mask_wdata,
    output interrupt_key, interrupt_eth, irq_cause, irq_ovf, busy
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected key/eth events queue in saturating counters, one 1-cycle request per
// event (2 cycles event-to-request), held off until rti/rsi. INTC_MASK_EN adds the per-source mask register.
module intr_ctrl #(
  parameter int CNT_W    = 2,
  parameter bit PRIO_KEY = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  intr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       sel, sel_nxt;   // one-hot {eth, key}
  logic             key_q, eth_q;
  logic             key_ev, eth_ev;
  logic [CNT_W-1:0] key_cnt, eth_cnt;
  logic [1:0]       ovf;
  logic [1:0]       mask;
  logic             key_elig, eth_elig;
  logic             dispatch;
  logic             key_dec, eth_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b0;
      eth_q <= 1'b0;
    end else begin
      key_q <= bus.key_evt;
      eth_q <= bus.eth_evt;
    end
  end

  assign key_ev = bus.key_evt & ~key_q;
  assign eth_ev = bus.eth_evt & ~eth_q;

`ifdef INTC_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mask <= 2'b00;
    else if (bus.mask_we)
      mask <= bus.mask_wdata;
  end
`else
  logic unused_mask;
  assign unused_mask = ^{bus.mask_we, bus.mask_wdata};
  assign mask        = 2'b00;
`endif

  assign key_elig = (key_cnt != '0) && !mask[0];
  assign eth_elig = (eth_cnt != '0) && !mask[1];

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    dispatch  = 1'b0;
    case (state)
      IDLE: begin
        if (key_elig || eth_elig) begin
          dispatch  = 1'b1;
          state_nxt = REQ;
          if (key_elig && (PRIO_KEY || !eth_elig))
            sel_nxt = 2'b01;
          else
            sel_nxt = 2'b10;
        end
      end
      REQ:     state_nxt = SERVICE;
      SERVICE: if (bus.rti || bus.rsi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign key_dec = dispatch & sel_nxt[0];
  assign eth_dec = dispatch & sel_nxt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'b00;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  // Overflow flags only when an event is actually dropped; a same-cycle dispatch makes room for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_cnt <= '0;
      eth_cnt <= '0;
      ovf     <= 2'b00;
    end else begin
      if (key_ev && !key_dec) begin
        if (key_cnt == CNT_MAX)
          ovf[0] <= 1'b1;
        else
          key_cnt <= key_cnt + CNT_ONE;
      end else if (!key_ev && key_dec) begin
        key_cnt <= key_cnt - CNT_ONE;
      end

      if (eth_ev && !eth_dec) begin
        if (eth_cnt == CNT_MAX)
          ovf[1] <= 1'b1;
        else
          eth_cnt <= eth_cnt + CNT_ONE;
      end else if (!eth_ev && eth_dec) begin
        eth_cnt <= eth_cnt - CNT_ONE;
      end
    end
  end

  assign bus.interrupt_key = (state == REQ) && sel[0];
  assign bus.interrupt_eth = (state == REQ) && sel[1];
  assign bus.irq_cause     = (state != IDLE) ? sel : 2'b00;
  assign bus.busy          = (state != IDLE);
  assign bus.irq_ovf       = ovf;

endmodule
